mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port byte-addressed simple_memory between the instruction-fetch (I) and
//  load/store (D) ports of the core. Round-robin grant, one access per cycle, valid/ready on
//  both sides. Drives the memory's read/write address, data and strobe; registers read data
//  into per-port responses. One outstanding response per port; out-of-range accesses are
//  blocked and flagged.
// PARAMETERS
//  pMemBytes    32'd176  memory size in bytes (44 words); legal iff addr+3 < pMemBytes
//  pFirstGrant  1'b0     port favoured by pointer after reset (0 = I, 1 = D)
//  pCntWidth    16       width of grant counters (ARB_PERF_CNT_EN only)
// PORTS
//  iwClk          in   1   clock
//  iwRst          in   1   reset, asynchronous, active-high
//  iwIReqValid    in   1   I read request valid
//  owIReqReady    out  1   I request granted this cycle (combinational)
//  iwIReqAddr     in   32  I byte address
//  owIRspValid    out  1   I response valid
//  orIRspData     out  32  I read data
//  owIRspErr      out  1   I response is out-of-range error
//  iwIRspReady    in   1   I response consumed
//  iwDReqValid    in   1   D request valid
//  owDReqReady    out  1   D request granted this cycle (combinational)
//  iwDReqAddr     in   32  D byte address
//  iwDReqWData    in   32  D write data
//  iwDReqWstrb    in   4   D byte strobes; 0 = read
//  owDRspValid    out  1   D response valid
//  orDRspData     out  32  D read data (read-back value on write)
//  owDRspErr      out  1   D response is out-of-range error
//  iwDRspReady    in   1   D response consumed
//  owMemReadAddr  out  32  to memory iwReadAddr
//  owMemWriteAddr out  32  to memory iwWriteAddr
//  owMemWriteData out  32  to memory iwWriteData
//  owMemWstrb     out  4   to memory iwWstrb
//  iwMemReadData  in   32  from memory orReadData (valid after negedge of access cycle)
// BEHAVIOUR
//  - Transfer on posedge when Valid && Ready. Port X eligible: XReqValid && (!XRspValid || XRspReady).
//  - Both eligible: grant port named by rPtr; one eligible: grant it; none: idle.
//  - Any grant sets rPtr to the other port; idle leaves rPtr unchanged. At most one Ready high.
//  - Memory side combinational from grant: ReadAddr = WriteAddr = granted addr; WriteData/Wstrb from D
//    when D granted, else Wstrb = 0. Idle: addresses 0, Wstrb 0. Memory writes then reads on negedge,
//    so a write's read-back reflects new bytes.
//  - Latency: grant in cycle N -> XRspValid=1 in N+1, data = iwMemReadData sampled at posedge ending N.
//  - Response held stable until XRspReady; rsp accepted and new grant in same cycle replaces it.
//  - Range: addr+3 >= pMemBytes (computed 33-bit, no wrap) -> Wstrb forced 0, grant still given,
//    response XRspErr=1, data 32'h0. Legal: Err=0.
//  - Reset (async, iwRst=1): RspValid/Err 0, RspData 0, rPtr = pFirstGrant, Ready 0, Wstrb 0
//    (Wstrb gated by !iwRst combinationally). Reset mid-access drops pending responses; no write issued.
//  - No FSM beyond rPtr and per-port response registers; arbitration fully decided each cycle.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs orIGrantCnt, orDGrantCnt [pCntWidth-1:0]; +1 per grant of that
//    port, saturate at all-ones, reset to 0; errored grants counted.
//  Not defined: ports absent, no counters; arbitration behaviour identical.
// TESTING
//  1 Mem[0x10..0x13]=44,33,22,11; I reads 0x10 -> IReqReady=1 same cycle, next cycle IRspValid=1, data 0x11223344.
//  2 I,D valid continuously, RspReady=1, pFirstGrant=0 -> grants I,D,I,D..., one Ready per cycle.
//  3 D write 0x20 data 0xAABBCCDD wstrb 4'b0011 over 0 -> MemWstrb=0011 one cycle; DRspData=0x0000CCDD.
//  4 IRspValid held with IRspReady=0, both valid -> only D granted; raise IRspReady -> I granted that cycle.
//  5 D write 0xAE wstrb 4'hF -> MemWstrb=0, DRspErr=1, DRspData=0; 0xAC read -> Err=0.
//  6 iwRst pulsed while IRspValid=1 -> IRspValid=0 immediately; after release, first dual request grants I.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressed memory port between instruction-fetch (I) and load/store (D).
// Optional per-port grant counters are enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter logic [31:0] pMemBytes   = 32'd176,
    parameter logic        pFirstGrant = 1'b0,
    parameter int          pCntWidth   = 16
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwIReqValid,
    output logic        owIReqReady,
    input  logic [31:0] iwIReqAddr,
    output logic        owIRspValid,
    output logic [31:0] orIRspData,
    output logic        owIRspErr,
    input  logic        iwIRspReady,
    input  logic        iwDReqValid,
    output logic        owDReqReady,
    input  logic [31:0] iwDReqAddr,
    input  logic [31:0] iwDReqWData,
    input  logic [3:0]  iwDReqWstrb,
    output logic        owDRspValid,
    output logic [31:0] orDRspData,
    output logic        owDRspErr,
    input  logic        iwDRspReady,
    output logic [31:0] owMemReadAddr,
    output logic [31:0] owMemWriteAddr,
    output logic [31:0] owMemWriteData,
    output logic [3:0]  owMemWstrb,
    input  logic [31:0] iwMemReadData
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [pCntWidth-1:0] orIGrantCnt,
    output logic [pCntWidth-1:0] orDGrantCnt
`endif
);

    logic        ptr_q, ptr_d;
    logic        i_rsp_valid_q, i_rsp_valid_d;
    logic        i_rsp_err_q, i_rsp_err_d;
    logic [31:0] i_rsp_data_q, i_rsp_data_d;
    logic        d_rsp_valid_q, d_rsp_valid_d;
    logic        d_rsp_err_q, d_rsp_err_d;
    logic [31:0] d_rsp_data_q, d_rsp_data_d;

    logic i_elig, d_elig;
    logic grant_i, grant_d;
    logic i_legal, d_legal;

    // A port may take a new grant only if its response slot is empty or being drained this cycle.
    always_comb begin
        i_elig  = iwIReqValid && (!i_rsp_valid_q || iwIRspReady);
        d_elig  = iwDReqValid && (!d_rsp_valid_q || iwDRspReady);
        grant_i = !iwRst && i_elig && (!d_elig || !ptr_q);
        grant_d = !iwRst && d_elig && (!i_elig || ptr_q);
        // 33-bit sums so addresses near 2^32 cannot wrap back into range.
        i_legal = ({1'b0, iwIReqAddr} + 33'd3) < {1'b0, pMemBytes};
        d_legal = ({1'b0, iwDReqAddr} + 33'd3) < {1'b0, pMemBytes};
    end

    assign owIReqReady = grant_i;
    assign owDReqReady = grant_d;

    always_comb begin
        owMemReadAddr  = 32'h0;
        owMemWriteData = 32'h0;
        owMemWstrb     = 4'h0;
        if (grant_i) begin
            owMemReadAddr = iwIReqAddr;
        end else if (grant_d) begin
            owMemReadAddr  = iwDReqAddr;
            owMemWriteData = iwDReqWData;
            owMemWstrb     = d_legal ? iwDReqWstrb : 4'h0;
        end
        owMemWriteAddr = owMemReadAddr;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_i) begin
            ptr_d = 1'b1;
        end else if (grant_d) begin
            ptr_d = 1'b0;
        end
    end

    always_comb begin
        i_rsp_valid_d = i_rsp_valid_q;
        i_rsp_err_d   = i_rsp_err_q;
        i_rsp_data_d  = i_rsp_data_q;
        if (grant_i) begin
            i_rsp_valid_d = 1'b1;
            i_rsp_err_d   = !i_legal;
            i_rsp_data_d  = i_legal ? iwMemReadData : 32'h0;
        end else if (iwIRspReady) begin
            i_rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        d_rsp_valid_d = d_rsp_valid_q;
        d_rsp_err_d   = d_rsp_err_q;
        d_rsp_data_d  = d_rsp_data_q;
        if (grant_d) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = !d_legal;
            d_rsp_data_d  = d_legal ? iwMemReadData : 32'h0;
        end else if (iwDRspReady) begin
            d_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            ptr_q         <= pFirstGrant;
            i_rsp_valid_q <= 1'b0;
            i_rsp_err_q   <= 1'b0;
            i_rsp_data_q  <= 32'h0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_err_q   <= 1'b0;
            d_rsp_data_q  <= 32'h0;
        end else begin
            ptr_q         <= ptr_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_err_q   <= i_rsp_err_d;
            i_rsp_data_q  <= i_rsp_data_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_err_q   <= d_rsp_err_d;
            d_rsp_data_q  <= d_rsp_data_d;
        end
    end

    assign owIRspValid = i_rsp_valid_q;
    assign owIRspErr   = i_rsp_err_q;
    assign orIRspData  = i_rsp_data_q;
    assign owDRspValid = d_rsp_valid_q;
    assign owDRspErr   = d_rsp_err_q;
    assign orDRspData  = d_rsp_data_q;

`ifdef ARB_PERF_CNT_EN
    localparam logic [pCntWidth-1:0] CntOne = {{(pCntWidth-1){1'b0}}, 1'b1};

    logic [pCntWidth-1:0] i_cnt_q, i_cnt_d;
    logic [pCntWidth-1:0] d_cnt_q, d_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        if (grant_i && (i_cnt_q != '1)) begin
            i_cnt_d = i_cnt_q + CntOne;
        end
        if (grant_d && (d_cnt_q != '1)) begin
            d_cnt_d = d_cnt_q + CntOne;
        end
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    assign orIGrantCnt = i_cnt_q;
    assign orDGrantCnt = d_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a negedge byte-memory stub
// and a transaction-level reference model (round-robin choice, byte array, response slots).
module tb_mem_port_arbiter;

    localparam int MEM_BYTES = 176;
    localparam int CNT_MAX   = 65535;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic [31:0] req_addr  [2];
    logic        rsp_ready [2];
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic        i_req_ready, d_req_ready;
    logic        i_rsp_valid, d_rsp_valid;
    logic        i_rsp_err, d_rsp_err;
    logic [31:0] i_rsp_data, d_rsp_data;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] i_cnt, d_cnt;
`endif

    mem_port_arbiter dut (
        .iwClk         (clk),
        .iwRst         (rst),
        .iwIReqValid   (req_valid[0]),
        .owIReqReady   (i_req_ready),
        .iwIReqAddr    (req_addr[0]),
        .owIRspValid   (i_rsp_valid),
        .orIRspData    (i_rsp_data),
        .owIRspErr     (i_rsp_err),
        .iwIRspReady   (rsp_ready[0]),
        .iwDReqValid   (req_valid[1]),
        .owDReqReady   (d_req_ready),
        .iwDReqAddr    (req_addr[1]),
        .iwDReqWData   (d_wdata),
        .iwDReqWstrb   (d_wstrb),
        .owDRspValid   (d_rsp_valid),
        .orDRspData    (d_rsp_data),
        .owDRspErr     (d_rsp_err),
        .iwDRspReady   (rsp_ready[1]),
        .owMemReadAddr (mem_raddr),
        .owMemWriteAddr(mem_waddr),
        .owMemWriteData(mem_wdata),
        .owMemWstrb    (mem_wstrb),
        .iwMemReadData (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .orIGrantCnt   (i_cnt),
        .orDGrantCnt   (d_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stub: write then read on the falling edge; out-of-range reads return junk.
    logic [7:0] stub_mem [MEM_BYTES];
    always @(negedge clk) begin
        int wa;
        int ra;
        wa = int'(mem_waddr);
        ra = int'(mem_raddr);
        if (mem_waddr < 32'd173) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) stub_mem[wa + b] = mem_wdata[8*b +: 8];
            end
        end
        if (mem_raddr < 32'd173)
            mem_rdata = {stub_mem[ra + 3], stub_mem[ra + 2], stub_mem[ra + 1], stub_mem[ra]};
        else
            mem_rdata = 32'hDEADBEEF;
    end

    // Reference model state
    logic [7:0]  ref_mem [MEM_BYTES];
    int          m_ptr;
    bit          m_valid [2];
    bit          m_err   [2];
    logic [31:0] m_data  [2];
    int          m_cnt   [2];

    int checks;
    int failures;
    logic       obs_i_rdy, obs_d_rdy;
    logic [3:0] obs_wstrb;

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    endfunction

    task automatic set_mem(input int a, input logic [7:0] v);
        stub_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0;
            m_err[p]   = 1'b0;
            m_data[p]  = 32'h0;
            m_cnt[p]   = 0;
        end
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_addr[p]  = 32'h0;
            rsp_ready[p] = 1'b1;
        end
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
    endtask

    // One clock of traffic: entered at posedge+1 with inputs set, leaves at the next posedge+1.
    task automatic step(input string tag);
        int          g;
        bit          legal;
        bit          el0, el1;
        logic [31:0] ea;
        logic [3:0]  ew;
        #1;
        el0 = req_valid[0] && (!m_valid[0] || rsp_ready[0]);
        el1 = req_valid[1] && (!m_valid[1] || rsp_ready[1]);
        if (el0 && el1)  g = m_ptr;
        else if (el0)    g = 0;
        else if (el1)    g = 1;
        else             g = -1;
        obs_i_rdy = i_req_ready;
        obs_d_rdy = d_req_ready;
        obs_wstrb = mem_wstrb;
        checks++;
        if ({i_req_ready, d_req_ready} !== {g == 0, g == 1}) begin
            failures++;
            $display("FAIL %s ready: got I=%b D=%b, required grant port %0d", tag, i_req_ready, d_req_ready, g);
        end
        ea = (g < 0) ? 32'h0 : req_addr[g];
        legal = (g >= 0) && (longint'(ea) + 3 < MEM_BYTES);
        ew = (g == 1 && legal) ? d_wstrb : 4'h0;
        checks++;
        if (mem_raddr !== ea || mem_waddr !== ea) begin
            failures++;
            $display("FAIL %s mem_addr: got r=%h w=%h, required %h", tag, mem_raddr, mem_waddr, ea);
        end
        checks++;
        if (mem_wstrb !== ew) begin
            failures++;
            $display("FAIL %s mem_wstrb: got %h, required %h", tag, mem_wstrb, ew);
        end
        if (g == 1) begin
            checks++;
            if (mem_wdata !== d_wdata) begin
                failures++;
                $display("FAIL %s mem_wdata: got %h, required %h", tag, mem_wdata, d_wdata);
            end
        end
        if (g >= 0)
            $display("txn %s: port=%s addr=%h wstrb=%h legal=%0d", tag, (g == 0) ? "I" : "D", ea,
                     (g == 1) ? d_wstrb : 4'h0, legal);
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (g == p) begin
                if (p == 1 && legal) begin
                    for (int b = 0; b < 4; b++)
                        if (d_wstrb[b]) ref_mem[int'(ea) + b] = d_wdata[8*b +: 8];
                end
                m_valid[p] = 1'b1;
                m_err[p]   = !legal;
                m_data[p]  = legal ? ref_word(int'(ea)) : 32'h0;
                if (m_cnt[p] < CNT_MAX) m_cnt[p]++;
            end else if (rsp_ready[p]) begin
                m_valid[p] = 1'b0;
            end
        end
        if (g >= 0) m_ptr = 1 - g;
        #1;
        checks++;
        if ({i_rsp_valid, d_rsp_valid} !== {m_valid[0], m_valid[1]}) begin
            failures++;
            $display("FAIL %s rsp_valid: got I=%b D=%b, required I=%b D=%b", tag, i_rsp_valid, d_rsp_valid,
                     m_valid[0], m_valid[1]);
        end
        if (m_valid[0]) begin
            checks++;
            if (i_rsp_err !== m_err[0] || i_rsp_data !== m_data[0]) begin
                failures++;
                $display("FAIL %s i_rsp: got err=%b data=%h, required err=%b data=%h", tag, i_rsp_err,
                         i_rsp_data, m_err[0], m_data[0]);
            end
        end
        if (m_valid[1]) begin
            checks++;
            if (d_rsp_err !== m_err[1] || d_rsp_data !== m_data[1]) begin
                failures++;
                $display("FAIL %s d_rsp: got err=%b data=%h, required err=%b data=%h", tag, d_rsp_err,
                         d_rsp_data, m_err[1], m_data[1]);
            end
        end
`ifdef ARB_PERF_CNT_EN
        checks++;
        if (i_cnt !== 16'(m_cnt[0]) || d_cnt !== 16'(m_cnt[1])) begin
            failures++;
            $display("FAIL %s grant_cnt: got I=%0d D=%0d, required I=%0d D=%0d", tag, i_cnt, d_cnt,
                     m_cnt[0], m_cnt[1]);
        end
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        d_wstrb      = 4'hF;
        @(posedge clk);
        #1;
        checks++;
        if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err} !== 6'b0 ||
            mem_wstrb !== 4'h0 || i_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b%b vld=%b%b err=%b%b wstrb=%h data=%h/%h, required all zero",
                     i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, mem_wstrb,
                     i_rsp_data, d_rsp_data);
        end
        rst = 1'b0;
        model_reset();
        idle_inputs();
    endtask

    task automatic test_read_basic();
        set_mem(16, 8'h44);
        set_mem(17, 8'h33);
        set_mem(18, 8'h22);
        set_mem(19, 8'h11);
        idle_inputs();
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h10;
        step("read_basic");
        checks++;
        if (obs_i_rdy !== 1'b1 || i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h11223344) begin
            failures++;
            $display("FAIL read_basic: got rdy=%b vld=%b data=%h, required 1 1 11223344", obs_i_rdy,
                     i_rsp_valid, i_rsp_data);
        end
        idle_inputs();
        step("read_basic_idle");
    endtask

    task automatic test_alternate();
        do_reset();
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_addr[0] = $urandom_range(0, 172);
            req_addr[1] = $urandom_range(0, 172);
            step("alternate");
            checks++;
            if (obs_i_rdy !== (k % 2 == 0) || obs_d_rdy !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL alternate[%0d]: got I=%b D=%b, required I=%b D=%b", k, obs_i_rdy, obs_d_rdy,
                         k % 2 == 0, k % 2 == 1);
            end
        end
        idle_inputs();
        step("alternate_idle");
    endtask

    task automatic test_partial_write();
        for (int a = 32; a < 36; a++) set_mem(a, 8'h00);
        idle_inputs();
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h20;
        d_wdata      = 32'hAABBCCDD;
        d_wstrb      = 4'b0011;
        step("partial_write");
        checks++;
        if (obs_wstrb !== 4'b0011 || d_rsp_data !== 32'h0000CCDD || d_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL partial_write: got wstrb=%b data=%h err=%b, required 0011 0000ccdd 0", obs_wstrb,
                     d_rsp_data, d_rsp_err);
        end
        idle_inputs();
        step("partial_write_idle");
        checks++;
        if (obs_wstrb !== 4'b0000) begin
            failures++;
            $display("FAIL partial_write_once: got wstrb=%b, required 0000", obs_wstrb);
        end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h04;
        step("bp_fill");
        req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr[0] = $urandom_range(0, 172);
            req_addr[1] = $urandom_range(0, 172);
            step("bp_hold");
            checks++;
            if (obs_i_rdy !== 1'b0 || obs_d_rdy !== 1'b1 || i_rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got I=%b D=%b ivld=%b, required 0 1 1", k, obs_i_rdy, obs_d_rdy,
                         i_rsp_valid);
            end
        end
        rsp_ready[0] = 1'b1;
        step("bp_release");
        checks++;
        if (obs_i_rdy !== 1'b1 || obs_d_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got I=%b D=%b, required 1 0", obs_i_rdy, obs_d_rdy);
        end
        idle_inputs();
        step("bp_idle");
    endtask

    task automatic test_range();
        idle_inputs();
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'hAE;
        d_wdata      = 32'h12345678;
        d_wstrb      = 4'hF;
        step("range_bad");
        checks++;
        if (obs_wstrb !== 4'h0 || d_rsp_err !== 1'b1 || d_rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL range_bad: got wstrb=%h err=%b data=%h, required 0 1 00000000", obs_wstrb,
                     d_rsp_err, d_rsp_data);
        end
        req_addr[1] = 32'hAC;
        d_wstrb     = 4'h0;
        step("range_edge");
        checks++;
        if (d_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL range_edge: got err=%b, required 0", d_rsp_err);
        end
        req_addr[0]  = 32'hFFFF_FFFE;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b0;
        step("range_wrap");
        idle_inputs();
        step("range_idle");
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h08;
        step("midrst_fill");
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (i_rsp_valid !== 1'b0 || i_req_ready !== 1'b0 || mem_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL midrst_async: got ivld=%b irdy=%b wstrb=%h, required 0 0 0", i_rsp_valid,
                     i_req_ready, mem_wstrb);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        req_addr[0]  = 32'h0C;
        req_addr[1]  = 32'h30;
        step("midrst_first");
        checks++;
        if (obs_i_rdy !== 1'b1 || obs_d_rdy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_first: got I=%b D=%b, required 1 0", obs_i_rdy, obs_d_rdy);
        end
        idle_inputs();
        step("midrst_idle");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                req_valid[p] = ($urandom_range(0, 3) != 0);
                req_addr[p]  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 180);
                rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            d_wdata = $urandom;
            d_wstrb = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step("random");
        end
        idle_inputs();
        step("random_idle");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        for (int a = 0; a < MEM_BYTES; a++) set_mem(a, 8'($urandom));
        model_reset();
        test_reset();
        test_read_basic();
        test_alternate();
        test_partial_write();
        test_backpressure();
        test_range();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
